// File: rtl/mmp_iddmm_drv.sv
// Operand loader and result buffer for an iterative Montgomery multiplier:
// streams N operand words into the multiplier RAMs, starts it, captures its N result words and replays them.
module mmp_iddmm_drv #(
  parameter int K       = 128,
  parameter int N       = 32,
  parameter int ADDR_W  = $clog2(N),
  parameter int TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [K-1:0]      op_x,
  input  logic [K-1:0]      op_y,
  input  logic [K-1:0]      op_m,
  input  logic [K-1:0]      op_m1,
  output logic [2:0]        wr_ena,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [K-1:0]      wr_x,
  output logic [K-1:0]      wr_y,
  output logic [K-1:0]      wr_m,
  output logic [K-1:0]      wr_m1,
  output logic              task_req,
  input  logic              task_end,
  input  logic              task_grant,
  input  logic [K-1:0]      task_res,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [K-1:0]      res_data,
  output logic              res_last,
  output logic              busy,
  output logic              err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N - 1);
  localparam logic [CNT_W-1:0]  TO_LAST  = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, LOAD, REQ, WAIT, DRAIN} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] load_idx, res_idx, drain_idx;
  logic              res_full;
  logic [CNT_W-1:0]  wait_cnt;
  logic [K-1:0]      res_buf [N];

  logic accept, last_load, in_wait, grant_ok, grant_bad, end_ok, end_bad;
  logic res_short, timeout_hit, drain_hs, drain_done, err_set, err_clr;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    op_ready    = rst_n && (state == IDLE || state == LOAD);
    accept      = op_valid && op_ready;
    last_load   = accept && (load_idx == LAST_IDX);
    in_wait     = (state == WAIT);
    grant_ok    = in_wait && task_grant && !res_full;
    grant_bad   = task_grant && (!in_wait || res_full);
    end_ok      = in_wait && task_end;
    end_bad     = task_end && !in_wait;
    // A grant arriving together with task_end still counts toward the word total.
    res_short   = end_ok && !(res_full || (grant_ok && res_idx == LAST_IDX));
    timeout_hit = in_wait && !task_end && (wait_cnt == TO_LAST);
    drain_hs    = (state == DRAIN) && res_ready;
    drain_done  = drain_hs && (drain_idx == LAST_IDX);
    err_set     = grant_bad || end_bad || res_short || timeout_hit;
    err_clr     = accept && (state == IDLE);

    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = last_load ? REQ : LOAD;
      LOAD:    if (last_load) state_next = REQ;
      REQ:     state_next = WAIT;
      WAIT: begin
        if (task_end)         state_next = DRAIN;
        else if (timeout_hit) state_next = IDLE;
      end
      DRAIN:   if (drain_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase

    busy      = (state != IDLE);
    res_valid = (state == DRAIN);
    res_last  = res_valid && (drain_idx == LAST_IDX);
    res_data  = res_valid ? res_buf[drain_idx] : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      load_idx  <= '0;
      res_idx   <= '0;
      res_full  <= 1'b0;
      drain_idx <= '0;
      wait_cnt  <= '0;
      wr_ena    <= 3'b000;
      wr_addr   <= '0;
      wr_x      <= '0;
      wr_y      <= '0;
      wr_m      <= '0;
      wr_m1     <= '0;
      task_req  <= 1'b0;
      err       <= 1'b0;
    end else begin
      wr_ena   <= accept ? 3'b111 : 3'b000;
      task_req <= (state == REQ);
      if (accept) begin
        wr_addr  <= load_idx;
        wr_x     <= op_x;
        wr_y     <= op_y;
        wr_m     <= op_m;
        load_idx <= last_load ? '0 : load_idx + 1'b1;
        if (state == IDLE) wr_m1 <= op_m1;
      end
      if (grant_ok) begin
        if (res_idx == LAST_IDX) res_full <= 1'b1;
        else                     res_idx  <= res_idx + 1'b1;
      end
      if (in_wait) wait_cnt <= (task_end || timeout_hit) ? '0 : wait_cnt + 1'b1;
      // Leaving WAIT by either path forgets the stored word count.
      if (end_ok || timeout_hit) begin
        res_idx  <= '0;
        res_full <= 1'b0;
      end
      if (drain_hs) drain_idx <= drain_done ? '0 : drain_idx + 1'b1;
      if (err_set)      err <= 1'b1;
      else if (err_clr) err <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (grant_ok) res_buf[res_idx] <= task_res;
  end

endmodule

// File: tb/tb_mmp_iddmm_drv.sv
// Randomized bench for mmp_iddmm_drv: an operation-level model predicts every output each cycle,
// and a few hand-derived latencies and counts pin that model down.
module tb_mmp_iddmm_drv;

  localparam int K       = 128;
  localparam int N       = 32;
  localparam int AW      = $clog2(N);
  localparam int TIMEOUT = 4096;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          op_valid;
  logic          op_ready;
  logic [K-1:0]  op_x, op_y, op_m, op_m1;
  logic [2:0]    wr_ena;
  logic [AW-1:0] wr_addr;
  logic [K-1:0]  wr_x, wr_y, wr_m, wr_m1;
  logic          task_req, task_end, task_grant;
  logic [K-1:0]  task_res;
  logic          res_valid, res_ready, res_last;
  logic [K-1:0]  res_data;
  logic          busy, err;

  always #5 clk = ~clk;

  mmp_iddmm_drv #(.K(K), .N(N), .ADDR_W(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_x(op_x), .op_y(op_y), .op_m(op_m), .op_m1(op_m1),
    .wr_ena(wr_ena), .wr_addr(wr_addr),
    .wr_x(wr_x), .wr_y(wr_y), .wr_m(wr_m), .wr_m1(wr_m1),
    .task_req(task_req), .task_end(task_end), .task_grant(task_grant), .task_res(task_res),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_last(res_last),
    .busy(busy), .err(err)
  );

  int nChecks = 0;
  int nFails  = 0;
  int cycle   = 0;

  // Reference model: what the driver has been told, not how it is built.
  bit           mValid = 1'b0;
  bit           mActive, mWaiting, mErr, mWrPend, mClean, prevStall;
  int           mLoaded, mReqAt, mStored, mWaitCycles, mWrAddr;
  logic [K-1:0] mWrX, mWrY, mWrM, mM1, prevResData;
  logic         prevLast;
  logic [K-1:0] mMem [N];
  logic [K-1:0] mDrain [$];

  // Core comparison: every check in the bench funnels through here.
  task automatic checkOutput(input string name, input logic [K-1:0] act, input logic [K-1:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    checkOutput(name, K'(act), K'(exp));
  endtask

  task automatic checkInt(input string name, input int act, input int exp);
    checkOutput(name, K'(act), K'(exp));
  endtask

  function automatic logic [K-1:0] randWord();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic void resetModel();
    mActive = 0; mWaiting = 0; mErr = 0; mWrPend = 0; mClean = 1; prevStall = 0;
    mLoaded = 0; mReqAt = -100; mStored = 0; mWaitCycles = 0; mWrAddr = 0;
    mDrain.delete();
  endfunction

  initial forever begin
    @(posedge clk);
    cycle++;
  end

  // Compare process: check this cycle's outputs on the falling edge, then advance the
  // model using the inputs that the coming rising edge will sample.
  initial begin : compareProc
    bit expReady, accept, errSet, word0;
    forever begin
      @(negedge clk);
      if (mValid) begin
        expReady = (rst_n === 1'b1) && (mLoaded < N);
        checkBit("op_ready", op_ready, expReady);
        checkBit("busy", busy, mActive);
        checkBit("err", err, mErr);
        checkBit("task_req", task_req, cycle == mReqAt);
        checkInt("wr_ena", int'(wr_ena), mWrPend ? 7 : 0);
        if (mWrPend) begin
          checkInt("wr_addr", int'(wr_addr), mWrAddr);
          checkOutput("wr_x", wr_x, mWrX);
          checkOutput("wr_y", wr_y, mWrY);
          checkOutput("wr_m", wr_m, mWrM);
          checkOutput("wr_m1", wr_m1, mM1);
        end else if (mClean) begin
          checkInt("rst_wr_addr", int'(wr_addr), 0);
          checkOutput("rst_wr_x", wr_x, '0);
          checkOutput("rst_wr_y", wr_y, '0);
          checkOutput("rst_wr_m", wr_m, '0);
          checkOutput("rst_wr_m1", wr_m1, '0);
        end
        checkBit("res_valid", res_valid, mDrain.size() != 0);
        if (mDrain.size() != 0) begin
          checkOutput("res_data", res_data, mDrain[0]);
          checkBit("res_last", res_last, mDrain.size() == 1);
        end else if (mClean) begin
          checkOutput("rst_res_data", res_data, '0);
          checkBit("rst_res_last", res_last, 1'b0);
        end
        if (prevStall) begin
          checkOutput("res_stable", res_data, prevResData);
          checkBit("res_last_stable", res_last, prevLast);
        end
      end

      if (rst_n === 1'b0) begin
        mValid = 1;
        resetModel();
      end else if (mValid) begin
        prevStall   = (mDrain.size() != 0) && !res_ready;
        prevResData = res_data;
        prevLast    = res_last;
        errSet      = 0;
        accept      = op_valid && expReady;
        word0       = accept && (mLoaded == 0);
        if (mDrain.size() != 0 && res_ready) begin
          void'(mDrain.pop_front());
          if (mDrain.size() == 0) begin
            mActive = 0;
            mLoaded = 0;
          end
        end
        if (task_grant) begin
          if (mWaiting && mStored < N) begin
            mMem[mStored] = task_res;
            mStored++;
          end else errSet = 1;
        end
        if (task_end) begin
          if (mWaiting) begin
            if (mStored != N) errSet = 1;
            for (int i = 0; i < N; i++) mDrain.push_back(mMem[i]);
            mWaiting = 0; mStored = 0; mWaitCycles = 0;
          end else errSet = 1;
        end else if (mWaiting) begin
          mWaitCycles++;
          if (mWaitCycles == TIMEOUT) begin
            errSet = 1;
            mWaiting = 0; mActive = 0; mLoaded = 0; mStored = 0; mWaitCycles = 0;
          end
        end
        mWrPend = accept;
        if (accept) begin
          mClean  = 0;
          mWrAddr = mLoaded;
          mWrX = op_x; mWrY = op_y; mWrM = op_m;
          if (word0) begin
            mM1     = op_m1;
            mActive = 1;
          end
          mLoaded++;
          if (mLoaded == N) mReqAt = cycle + 2;
        end
        if (cycle + 1 == mReqAt) mWaiting = 1;
        if (errSet)     mErr = 1;
        else if (word0) mErr = 0;
      end
    end
  end

  // One whole operation: load N words, play the multiplier, then drain the results.
  task automatic applyStimulus(input int nGrants, input bit doEnd, input bit endWithGrant,
                               input int readyMode, input bit holdValid, input bit expErr);
    int loaded, guard, firstAcc, lastAcc, seen, drained;
    bit clearChecked, done;
    loaded = 0; guard = 0; firstAcc = 0; lastAcc = 0; clearChecked = 0;
    while (loaded < N && guard < 20 * N) begin
      op_valid = holdValid || ($urandom_range(0, 3) != 0);
      op_x = randWord(); op_y = randWord(); op_m = randWord(); op_m1 = randWord();
      @(negedge clk);
      if (loaded == 1 && !clearChecked) begin
        checkBit("err_clear", err, 1'b0);
        clearChecked = 1;
      end
      if (op_valid && op_ready) begin
        if (loaded == 0) firstAcc = cycle;
        lastAcc = cycle;
        loaded++;
      end
      @(posedge clk); #1;
      guard++;
    end
    op_valid = 0;
    if (loaded < N) begin
      checkInt("load_bound", loaded, N);
      return;
    end
    if (holdValid) checkInt("b2b_span", lastAcc - firstAcc, N - 1);

    seen = 0;
    for (int k = 1; k <= 8 && seen == 0; k++) begin
      @(negedge clk);
      if (task_req) seen = k;
      @(posedge clk); #1;
    end
    checkInt("req_latency", seen, 2);
    if (seen == 0) return;

    if (!doEnd) begin
      for (int k = 1; k <= TIMEOUT; k++) begin
        @(negedge clk);
        if (k == TIMEOUT - 1) checkBit("timeout_busy_before", busy, 1'b1);
        if (k == TIMEOUT) begin
          checkBit("timeout_busy", busy, 1'b0);
          checkBit("timeout_err", err, 1'b1);
          checkBit("timeout_ready", op_ready, 1'b1);
        end
        @(posedge clk); #1;
      end
      return;
    end

    for (int g = 0; g < nGrants; g++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      task_grant = 1;
      task_res   = randWord();
      task_end   = endWithGrant && (g == nGrants - 1);
      @(posedge clk); #1;
      task_grant = 0;
      task_end   = 0;
    end
    if (!endWithGrant) begin
      task_end = 1;
      @(posedge clk); #1;
      task_end = 0;
    end

    done = 0; drained = 0;
    for (int k = 0; k < 20 * N && !done; k++) begin
      case (readyMode)
        0:       res_ready = 1;
        1:       res_ready = (k % 2 == 0);
        default: res_ready = ($urandom_range(0, 1) == 1);
      endcase
      @(negedge clk);
      if (res_valid && res_ready) begin
        drained++;
        if (res_last) done = 1;
      end
      @(posedge clk); #1;
    end
    res_ready = 0;
    checkInt("drain_count", drained, N);
    checkBit("op_err", err, expErr);
    checkBit("op_idle", busy, 1'b0);
  endtask

  // Partial load, a stray grant, then a one-cycle reset that must wipe everything.
  task automatic resetMidLoad();
    int loaded = 0;
    int guard = 0;
    op_valid = 1;
    while (loaded < 10 && guard < 100) begin
      op_x = randWord(); op_y = randWord(); op_m = randWord(); op_m1 = randWord();
      @(negedge clk);
      if (op_valid && op_ready) loaded++;
      @(posedge clk); #1;
      guard++;
    end
    checkInt("partial_load", loaded, 10);
    op_valid = 0;
    task_grant = 1;
    task_res = randWord();
    @(posedge clk); #1;
    task_grant = 0;
    @(negedge clk);
    checkBit("stray_grant_err", err, 1'b1);
    @(posedge clk); #1;
    rst_n = 0;
    @(negedge clk);
    checkBit("rst_ready_low", op_ready, 1'b0);
    @(posedge clk); #1;
    rst_n = 1;
    @(negedge clk);
    checkBit("mid_rst_ready", op_ready, 1'b1);
    checkBit("mid_rst_busy", busy, 1'b0);
    checkBit("mid_rst_err", err, 1'b0);
    checkInt("mid_rst_wr_ena", int'(wr_ena), 0);
    checkInt("mid_rst_wr_addr", int'(wr_addr), 0);
    checkOutput("mid_rst_wr_m1", wr_m1, '0);
    checkBit("mid_rst_res_valid", res_valid, 1'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    nFails++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin
    rst_n = 0; op_valid = 0; op_x = '0; op_y = '0; op_m = '0; op_m1 = '0;
    task_end = 0; task_grant = 0; task_res = '0; res_ready = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    checkBit("init_ready", op_ready, 1'b1);
    checkBit("init_busy", busy, 1'b0);
    checkBit("init_err", err, 1'b0);
    checkInt("init_wr_ena", int'(wr_ena), 0);
    checkBit("init_task_req", task_req, 1'b0);
    checkBit("init_res_valid", res_valid, 1'b0);
    @(posedge clk); #1;
    $display("[TB] back-to-back load, full result, sink always ready");
    applyStimulus(N, 1, 0, 0, 1, 0);
    $display("[TB] gappy load, end with last grant, sink toggling");
    applyStimulus(N, 1, 1, 1, 0, 0);
    $display("[TB] short result (N-1 grants)");
    applyStimulus(N - 1, 1, 0, 2, 0, 1);
    $display("[TB] full result after error, random sink");
    applyStimulus(N, 1, 0, 2, 0, 0);
    $display("[TB] one grant too many");
    applyStimulus(N + 1, 1, 0, 0, 0, 1);
    $display("[TB] multiplier never finishes");
    applyStimulus(0, 0, 0, 0, 0, 1);
    $display("[TB] reset in the middle of a load");
    resetMidLoad();
    $display("[TB] clean operation after reset");
    applyStimulus(N, 1, 1, 2, 1, 0);
    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
